// File: rtl/wb_master_ctrl.sv
// wb_master_ctrl: single-outstanding Wishbone B4 pipelined master.
// Define WB_MASTER_TIMEOUT_EN to build the ack timeout / abort path.
module wb_master_ctrl #(
    parameter int ADDR_BITS    = 32,
    parameter int DATA_BITS    = 32,
    parameter int TIMEOUT      = 255,
    parameter int TIMEOUT_BITS = 8
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_we_i,
    input  logic [ADDR_BITS-1:0] cmd_adr_i,
    input  logic [DATA_BITS-1:0] cmd_dat_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DATA_BITS-1:0] rsp_dat_o,
    output logic                 rsp_err_o,
    output logic                 wb_cyc_o,
    output logic                 wb_stb_o,
    output logic                 wb_we_o,
    output logic [ADDR_BITS-1:0] wb_adr_o,
    output logic [DATA_BITS-1:0] wb_dat_o,
    input  logic [DATA_BITS-1:0] wb_dat_i,
    input  logic                 wb_ack_i,
    input  logic                 wb_stall_i
);

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        WAIT_ACK,
        RESPOND
    } state_e;

    state_e               state_q, state_d;
    logic                 cmd_ready_q, cmd_ready_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [DATA_BITS-1:0] rsp_dat_q, rsp_dat_d;
    logic                 rsp_err_q, rsp_err_d;
    logic                 cyc_q, cyc_d;
    logic                 stb_q, stb_d;
    logic                 we_q, we_d;
    logic [ADDR_BITS-1:0] adr_q, adr_d;
    logic [DATA_BITS-1:0] dat_q, dat_d;
    logic                 expired;

    if (TIMEOUT < 2 || TIMEOUT >= (1 << TIMEOUT_BITS)) begin : g_bad_cfg
        $error("wb_master_ctrl: TIMEOUT must be >= 2 and below 2**TIMEOUT_BITS");
    end

`ifdef WB_MASTER_TIMEOUT_EN
    logic [TIMEOUT_BITS-1:0] tmo_q;

    // Count cycles the bus cycle has been open for the current command
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || state_q == IDLE) begin
            tmo_q <= '0;
        end else if (state_q == REQUEST || state_q == WAIT_ACK) begin
            tmo_q <= tmo_q + 1'b1;
        end
    end

    // Counter reaches TIMEOUT on this edge
    assign expired = (tmo_q == TIMEOUT_BITS'(TIMEOUT - 1));
`else
    assign expired = 1'b0;
`endif

    // State and registered outputs
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid_i && cmd_ready_q) begin
                    we_d        = cmd_we_i;
                    adr_d       = cmd_adr_i;
                    dat_d       = cmd_dat_i;
                    cmd_ready_d = 1'b0;
                    cyc_d       = 1'b1;
                    stb_d       = 1'b1;
                    state_d     = REQUEST;
                end
            end
            REQUEST: begin
                if (expired) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_err_d   = 1'b1;
                    rsp_dat_d   = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESPOND;
                end else if (!wb_stall_i) begin
                    stb_d   = 1'b0;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (wb_ack_i) begin
                    cyc_d       = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_dat_d   = we_q ? '0 : wb_dat_i;
                    rsp_valid_d = 1'b1;
                    state_d     = RESPOND;
                end else if (expired) begin
                    cyc_d       = 1'b0;
                    rsp_err_d   = 1'b1;
                    rsp_dat_d   = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESPOND;
                end
            end
            RESPOND: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready_o = cmd_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_err_o   = rsp_err_q;
    assign wb_cyc_o    = cyc_q;
    assign wb_stb_o    = stb_q;
    assign wb_we_o     = we_q;
    assign wb_adr_o    = adr_q;
    assign wb_dat_o    = dat_q;

endmodule
